// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU sequencer: done arrives WIDTH+1 cycles after acceptance, or 1 cycle for a zero divisor.
// stall holds the pipeline while start is high, drops in the done cycle, and annul abandons the op with no result.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             negQ, negR;

  logic             negA, negB, accept;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff, remNext, quoNext, qFinal, rFinal;
  logic             geq;

  assign negA   = signed_op & opa[WIDTH-1];
  assign negB   = signed_op & opb[WIDTH-1];
  assign magA   = negA ? (~opa + ONE) : opa;
  assign magB   = negB ? (~opb + ONE) : opb;
  assign accept = start & ~annul;

  // One restoring step; the extra top bit of remShift keeps the compare exact.
  assign remShift = {rem, quo[WIDTH-1]};
  assign geq      = remShift >= {1'b0, divisor};
  assign diff     = remShift[WIDTH-1:0] - divisor;
  assign remNext  = geq ? diff : remShift[WIDTH-1:0];
  assign quoNext  = {quo[WIDTH-2:0], geq};
  assign qFinal   = negQ ? (~quoNext + ONE) : quoNext;
  assign rFinal   = negR ? (~remNext + ONE) : remNext;

  assign done  = (state == DONE);
  assign busy  = (state != IDLE);
  assign stall = start & ~done & ~annul;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = (opb == '0) ? DONE : RUN;
      RUN: begin
        if (annul)             stateNext = IDLE;
        else if (counter == 0) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (accept) begin
          rem     <= '0;
          quo     <= magA;
          divisor <= magB;
          negQ    <= negA ^ negB;
          negR    <= negA;
          counter <= CW'(WIDTH - 1);
          // Zero divisor bypasses the iteration entirely.
          if (opb == '0) begin
            hi <= opa;
            lo <= '1;
          end
        end
        RUN: if (!annul) begin
          rem     <= remNext;
          quo     <= quoNext;
          counter <= counter - CW'(1);
          if (counter == 0) begin
            hi <= rFinal;
            lo <= qFinal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
